// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states,
// IF/ID update actions, the skid entry layout and PC increment helper.
package if_stage_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    SKID  = 2'd1,
    DRAIN = 2'd2
  } fetchState_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_MEM    = 2'd2,
    IFID_SKID   = 2'd3
  } ifIdAction_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetchEntry_t;

  localparam logic [31:0] PC_INC = 32'd4;
  // A bubble carries no meaningful return address, so its PC+4 is cleared.
  localparam logic [31:0] BUBBLE_PC4 = 32'd0;

  function automatic logic [31:0] incPc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding an instruction that returned while the
// pipeline was stalled. Priority: clear, then load, then drain.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  fetchEntry_t loadEntry,
  output fetchEntry_t entry,
  output logic        valid
);

  fetchEntry_t entry_r;
  logic        valid_r;

  // Entry storage and occupancy flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      entry_r <= '{instr: 32'd0, pc4: 32'd0};
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      entry_r <= loadEntry;
      valid_r <= 1'b1;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign entry = entry_r;
  assign valid = valid_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and imem handshake.
// Optional IF_PERF_CNT_EN adds saturating stall/bubble counters.
module if_fetch_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pc_stall_i,
  input  logic        if_id_stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic        fetch_busy_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  fetchState_e state_r, nextState_s;
  ifIdAction_e ifIdAct_s;
  logic [31:0] pc_r, nextPc_s, pcInc_s;
  logic [31:0] ifIdInstr_r, ifIdPc4_r;
  logic        ifIdValid_r;
  logic        req_r, busy_r;
  logic        stall_s, flushEff_s;
  logic        skidLoad_s, skidDrain_s, skidClear_s, skidValid_s;
  fetchEntry_t skidEntry_s;

  assign stall_s    = pc_stall_i | if_id_stall_i;
  assign flushEff_s = flush_i & ~if_id_stall_i;
  assign pcInc_s    = incPc(pc_r);

  if_skid_buf uSkid (
    .clk       (clk_i),
    .rstN      (rst_n_i),
    .load      (skidLoad_s),
    .drain     (skidDrain_s),
    .clear     (skidClear_s),
    .loadEntry ('{instr: imem_rdata_i, pc4: pcInc_s}),
    .entry     (skidEntry_s),
    .valid     (skidValid_s)
  );

  // Next-state, PC and IF/ID decisions; a flush outranks everything else.
  always_comb begin
    nextState_s = state_r;
    nextPc_s    = pc_r;
    ifIdAct_s   = if_id_stall_i ? IFID_HOLD : IFID_BUBBLE;
    skidLoad_s  = 1'b0;
    skidDrain_s = 1'b0;
    skidClear_s = 1'b0;
    if (flushEff_s) begin
      nextPc_s    = branch_target_i;
      skidClear_s = 1'b1;
      ifIdAct_s   = IFID_BUBBLE;
      case (state_r)
        REQ:     nextState_s = imem_ready_i ? REQ : DRAIN;
        SKID:    nextState_s = REQ;
        DRAIN:   nextState_s = imem_ready_i ? REQ : DRAIN;
        default: nextState_s = REQ;
      endcase
    end else begin
      case (state_r)
        REQ: begin
          if (imem_ready_i) begin
            nextPc_s = pcInc_s;
            if (stall_s) begin
              skidLoad_s  = 1'b1;
              nextState_s = SKID;
            end else begin
              ifIdAct_s = IFID_MEM;
            end
          end else begin
            nextState_s = REQ;
          end
        end
        SKID: begin
          if (!stall_s) begin
            ifIdAct_s   = IFID_SKID;
            skidDrain_s = 1'b1;
            nextState_s = REQ;
          end else begin
            nextState_s = SKID;
          end
        end
        DRAIN: begin
          if (imem_ready_i) begin
            nextState_s = REQ;
          end else begin
            nextState_s = DRAIN;
          end
        end
        default: begin
          nextState_s = REQ;
          ifIdAct_s   = IFID_BUBBLE;
        end
      endcase
    end
  end

  // FSM state, PC and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= REQ;
      pc_r    <= RESET_PC;
      req_r   <= 1'b1;
      busy_r  <= 1'b1;
    end else begin
      state_r <= nextState_s;
      pc_r    <= nextPc_s;
      req_r   <= (nextState_s == REQ);
      busy_r  <= (nextState_s == REQ) || (nextState_s == DRAIN);
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ifIdInstr_r <= NOP_INSTR;
      ifIdPc4_r   <= 32'd0;
      ifIdValid_r <= 1'b0;
    end else begin
      case (ifIdAct_s)
        IFID_MEM: begin
          ifIdInstr_r <= imem_rdata_i;
          ifIdPc4_r   <= pcInc_s;
          ifIdValid_r <= 1'b1;
        end
        IFID_SKID: begin
          ifIdInstr_r <= skidEntry_s.instr;
          ifIdPc4_r   <= skidEntry_s.pc4;
          ifIdValid_r <= skidValid_s;
        end
        IFID_BUBBLE: begin
          ifIdInstr_r <= NOP_INSTR;
          ifIdPc4_r   <= BUBBLE_PC4;
          ifIdValid_r <= 1'b0;
        end
        default: begin
          ifIdInstr_r <= ifIdInstr_r;
          ifIdPc4_r   <= ifIdPc4_r;
          ifIdValid_r <= ifIdValid_r;
        end
      endcase
    end
  end

  assign imem_req_o    = req_r;
  assign imem_addr_o   = pc_r;
  assign fetch_busy_o  = busy_r;
  assign if_id_instr_o = ifIdInstr_r;
  assign if_id_pc4_o   = ifIdPc4_r;
  assign if_id_valid_o = ifIdValid_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stallCnt_r, bubbleCnt_r;

  // Saturating stall and bubble counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stallCnt_r  <= 32'd0;
      bubbleCnt_r <= 32'd0;
    end else begin
      if (stall_s && (stallCnt_r != 32'hFFFF_FFFF)) begin
        stallCnt_r <= stallCnt_r + 32'd1;
      end else begin
        stallCnt_r <= stallCnt_r;
      end
      if ((ifIdAct_s == IFID_BUBBLE) && (bubbleCnt_r != 32'hFFFF_FFFF)) begin
        bubbleCnt_r <= bubbleCnt_r + 32'd1;
      end else begin
        bubbleCnt_r <= bubbleCnt_r;
      end
    end
  end

  assign stall_cnt_o  = stallCnt_r;
  assign bubble_cnt_o = bubbleCnt_r;
`endif

endmodule
